// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle core: opcodes, instruction field positions
// and the control FSM state type.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_LD   = 6'd6;
  localparam logic [5:0] OP_ST   = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_JMP  = 6'd9;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam int OPC_LSB = 26;
  localparam int RD_LSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_W   = 16;

endpackage

// File: rtl/multicycle_cpu_regfile.sv
// Architectural register file: two combinational read ports, one clocked write
// port; register 0 is hardwired to zero.
module regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_a,
  output logic [DATA_W-1:0]            rdata_a,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_b,
  output logic [DATA_W-1:0]            rdata_b
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle core with a single shared memory port; FETCH, DECODE, EXEC, MEM, WB
// states, HALT is terminal until reset.
// state  | meaning
// FETCH  | read M[PC] into IR, PC+1 on handshake
// DECODE | latch operands, HALT opcode stops the core
// EXEC   | ALU / address / branch resolution
// MEM    | data load or store, held until mem_ready
// WB     | register write and out update
// HALT   | frozen, no requests
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] out,
  output logic              halted
);

  localparam int RW = $clog2(REG_COUNT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [5:0]        opcode;
  logic [RW-1:0]     rd_idx, rs_idx, rt_idx, rb_idx;
  logic [DATA_W-1:0] imm_sext;
  logic [ADDR_W-1:0] imm_pc;
  logic [ADDR_W-1:0] imm_abs;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic              rf_we;
  logic              unused_ir;

  assign opcode   = ir_q[OPC_LSB +: 6];
  assign rd_idx   = ir_q[RD_LSB +: RW];
  assign rs_idx   = ir_q[RS_LSB +: RW];
  assign rt_idx   = ir_q[RT_LSB +: RW];
  assign imm_sext = DATA_W'($signed(ir_q[IMM_W-1:0]));
  assign imm_pc   = ADDR_W'($signed(ir_q[IMM_W-1:0]));
  assign imm_abs  = ADDR_W'(ir_q[IMM_W-1:0]);
  assign unused_ir = ^ir_q;

  // Stores and branches compare/store rd, so port B reads rd instead of rt.
  assign rb_idx = ((opcode == OP_ST) || (opcode == OP_BEQ)) ? rd_idx : rt_idx;

  regfile #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (reset),
    .we     (rf_we),
    .waddr  (rd_idx),
    .wdata  (res_q),
    .raddr_a(rs_idx),
    .rdata_a(rf_rdata_a),
    .raddr_b(rb_idx),
    .rdata_b(rf_rdata_b)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    out_d   = out_q;
    rf_we   = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          ir_d    = 32'(mem_rdata);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rf_rdata_a;
        b_d     = rf_rdata_b;
        state_d = (opcode == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_ADD:  begin res_d = a_q + b_q;      state_d = WB;  end
          OP_SUB:  begin res_d = a_q - b_q;      state_d = WB;  end
          OP_AND:  begin res_d = a_q & b_q;      state_d = WB;  end
          OP_OR:   begin res_d = a_q | b_q;      state_d = WB;  end
          OP_ADDI: begin res_d = a_q + imm_sext; state_d = WB;  end
          OP_LD,
          OP_ST:   begin res_d = a_q + imm_sext; state_d = MEM; end
          OP_BEQ: begin
            if (a_q == b_q) begin
              pc_d = pc_q + imm_pc;
            end
          end
          OP_JMP:  pc_d = imm_abs;
          default: ;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LD) begin
            res_d   = mem_rdata;
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WB: begin
        rf_we = 1'b1;
        if (rd_idx != '0) begin
          out_d = res_q;
        end
        state_d = FETCH;
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  // Gating with reset drops an in-flight request the moment reset asserts.
  assign mem_req   = reset && ((state_q == FETCH) || (state_q == MEM));
  assign mem_we    = reset && (state_q == MEM) && (opcode == OP_ST);
  assign mem_addr  = (state_q == MEM) ? ADDR_W'(res_q) : pc_q;
  assign mem_wdata = b_q;
  assign out       = out_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed program tests for multicycle_cpu against a zero-wait memory model
// with an optional stall control.
module tb_multicycle_cpu;

  localparam int DW = 32;
  localparam int RC = 16;
  localparam int AW = 16;

  localparam int OP_ADD = 1, OP_SUB = 2, OP_ADDI = 5, OP_LD = 6, OP_ST = 7;
  localparam int OP_BEQ = 8, OP_JMP = 9, OP_HALT = 63;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          mem_req, mem_we, mem_ready, halted;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, out;

  always #5 clk = ~clk;

  multicycle_cpu #(.DATA_W(DW), .REG_COUNT(RC), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .out      (out),
    .halted   (halted)
  );

  logic [31:0] prog [1024];
  logic [31:0] mem  [1024];
  int          cyc;
  int          rd_addr[$];
  int          rd_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          exp_a[$];
  int          exp_c[$];

  assign mem_ready = ~stall;
  assign mem_rdata = mem[mem_addr[9:0]];

  // Memory reloads from prog while in reset; cycle 1 is the first edge after release.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= prog[i];
    end else begin
      cyc <= cyc + 1;
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          mem[mem_addr[9:0]] <= mem_wdata;
          wr_addr.push_back(int'(mem_addr));
          wr_data.push_back(mem_wdata);
        end else begin
          rd_addr.push_back(int'(mem_addr));
          rd_cyc.push_back(cyc + 1);
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ri(input int op, input int rd, input int rs, input int rt);
    return {6'(op), 5'(rd), 5'(rs), 5'(rt), 11'd0};
  endfunction

  function automatic logic [31:0] ii(input int op, input int rd, input int rs, input int imm);
    return {6'(op), 5'(rd), 5'(rs), 16'(imm)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_req"}, mem_req, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_rst_out"}, out, 0);
    chk({tag, "_rst_halted"}, halted, 0);
    rst_n = 1'b1;
    #1;
    chk({tag, "_first_req"}, mem_req, 1);
    chk({tag, "_first_addr"}, mem_addr, 0);
    chk({tag, "_first_we"}, mem_we, 0);
  endtask

  task automatic run_halt(input string tag, input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halt_reached"}, halted, 1);
  endtask

  task automatic chk_reads(input string tag, input int base);
    chk({tag, "_nreads"}, rd_addr.size() - base, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (base + i < rd_addr.size()) begin
        chk($sformatf("%s_raddr%0d", tag, i), rd_addr[base + i], exp_a[i]);
        chk($sformatf("%s_rcyc%0d", tag, i), rd_cyc[base + i], exp_c[i]);
      end
    end
  endtask

  initial begin
    int rb, wb, bad;

    // Test 1: ADDI/ADDI/ADD/HALT timing and idle after HALT
    clear_prog();
    prog[0] = ii(OP_ADDI, 1, 0, 5);
    prog[1] = ii(OP_ADDI, 2, 0, 7);
    prog[2] = ri(OP_ADD, 3, 1, 2);
    prog[3] = ii(OP_HALT, 0, 0, 0);
    do_reset("t1");
    rb = rd_addr.size();
    step(4);
    chk("t1_out_r1", out, 5);
    step(8);
    chk("t1_out_r3", out, 12);
    step(1);
    chk("t1_halted_c13", halted, 0);
    step(1);
    chk("t1_halted_c14", halted, 1);
    step(2);
    chk("t1_halted_c16", halted, 1);
    exp_a = '{0, 1, 2, 3};
    exp_c = '{1, 5, 9, 13};
    chk_reads("t1", rb);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) bad++;
    end
    chk("t1_idle_req", bad, 0);
    chk("t1_idle_nreads", rd_addr.size() - rb, 4);
    chk("t1_out_final", out, 12);

    // Test 2: ST/LD round trip, r0 write discard, SUB wrap
    clear_prog();
    prog[0] = ii(OP_ADDI, 1, 0, 5);
    prog[1] = ii(OP_ADDI, 2, 0, 7);
    prog[2] = ri(OP_ADD, 3, 1, 2);
    prog[3] = ii(OP_ST, 3, 0, 'h40);
    prog[4] = ii(OP_LD, 4, 0, 'h40);
    prog[5] = ii(OP_ADDI, 0, 0, 9);
    prog[6] = ii(OP_ADDI, 6, 0, 1);
    prog[7] = ri(OP_SUB, 7, 0, 6);
    prog[8] = ii(OP_ST, 4, 0, 'h41);
    prog[9] = ii(OP_HALT, 0, 0, 0);
    do_reset("t2");
    rb = rd_addr.size();
    wb = wr_addr.size();
    step(25);
    chk("t2_out_after_r0_write", out, 12);
    run_halt("t2", 100);
    chk("t2_out_sub", out, 32'hFFFF_FFFF);
    exp_a = '{0, 1, 2, 3, 4, 'h40, 5, 6, 7, 8, 9};
    exp_c = '{1, 5, 9, 13, 17, 20, 22, 26, 30, 34, 38};
    chk_reads("t2", rb);
    chk("t2_nwrites", wr_addr.size() - wb, 2);
    if (wr_addr.size() - wb == 2) begin
      chk("t2_st_addr", wr_addr[wb], 'h40);
      chk("t2_st_data", wr_data[wb], 12);
      chk("t2_st_r4_addr", wr_addr[wb + 1], 'h41);
      chk("t2_st_r4_data", wr_data[wb + 1], 12);
    end

    // Test 3: three-cycle fetch stall
    clear_prog();
    prog[0] = ii(OP_ADDI, 1, 0, 3);
    prog[1] = ii(OP_ADDI, 2, 1, 4);
    prog[2] = ii(OP_HALT, 0, 0, 0);
    do_reset("t3");
    rb = rd_addr.size();
    step(4);
    stall = 1'b1;
    chk("t3_stall_addr0", mem_addr, 1);
    step(1);
    chk("t3_stall_addr1", mem_addr, 1);
    step(1);
    chk("t3_stall_addr2", mem_addr, 1);
    step(1);
    stall = 1'b0;
    chk("t3_stall_addr3", mem_addr, 1);
    chk("t3_stall_req3", mem_req, 1);
    step(4);
    chk("t3_out", out, 7);
    run_halt("t3", 50);
    exp_a = '{0, 1, 2};
    exp_c = '{1, 8, 12};
    chk_reads("t3", rb);

    // Test 4: BEQ taken, BEQ not taken, JMP
    clear_prog();
    prog[0]     = ii(OP_ADDI, 1, 0, 1);
    prog[1]     = ii(OP_BEQ, 1, 1, 2);
    prog[2]     = ii(OP_ADDI, 2, 0, 'h55);
    prog[3]     = ii(OP_ADDI, 2, 0, 'h66);
    prog[4]     = ii(OP_BEQ, 1, 0, 3);
    prog[5]     = ii(OP_JMP, 0, 0, 'h10);
    prog[6]     = ii(OP_ADDI, 2, 0, 'h77);
    prog['h10]  = ii(OP_ADDI, 3, 0, 'h12);
    prog['h11]  = ii(OP_HALT, 0, 0, 0);
    do_reset("t4");
    rb = rd_addr.size();
    wb = wr_addr.size();
    run_halt("t4", 60);
    chk("t4_out", out, 'h12);
    exp_a = '{0, 1, 4, 5, 'h10, 'h11};
    exp_c = '{1, 5, 8, 11, 14, 18};
    chk_reads("t4", rb);
    chk("t4_nwrites", wr_addr.size() - wb, 0);

    // Test 5: reset asserted during the MEM cycle of a store
    clear_prog();
    prog[0] = ii(OP_ADDI, 1, 0, 9);
    prog[1] = ii(OP_ST, 1, 0, 'h40);
    prog[2] = ii(OP_HALT, 0, 0, 0);
    do_reset("t5");
    wb = wr_addr.size();
    step(7);
    chk("t5_mem_req", mem_req, 1);
    chk("t5_mem_we", mem_we, 1);
    chk("t5_mem_addr", mem_addr, 'h40);
    chk("t5_mem_wdata", mem_wdata, 9);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_req", mem_req, 0);
    chk("t5_abort_we", mem_we, 0);
    repeat (2) @(negedge clk);
    chk("t5_no_write", wr_addr.size() - wb, 0);
    rst_n = 1'b1;
    #1;
    chk("t5_refetch_req", mem_req, 1);
    chk("t5_refetch_addr", mem_addr, 0);
    rb = rd_addr.size();
    run_halt("t5", 50);
    exp_a = '{0, 1, 2};
    exp_c = '{1, 5, 9};
    chk_reads("t5", rb);
    chk("t5_nwrites", wr_addr.size() - wb, 1);
    if (wr_addr.size() - wb == 1) begin
      chk("t5_st_addr", wr_addr[wb], 'h40);
      chk("t5_st_data", wr_data[wb], 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL take parameter DATA_W, default 32, datapath and register width, 16..32.
REQ-002 SHALL take parameter REG_COUNT, default 16, number of architectural registers, power of 2, 2..32.
REQ-003 SHALL take parameter ADDR_W, default 16, word-address width of the memory port and PC.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mem_req  output  1  memory access request.
REQ-007 SHALL have port mem_we  output  1  write when 1, read when 0; valid with mem_req.
REQ-008 SHALL have port mem_addr  output  ADDR_W  word address.
REQ-009 SHALL have port mem_wdata  output  DATA_W  store data.
REQ-010 SHALL have port mem_rdata  input  DATA_W  read data, valid when mem_ready=1.
REQ-011 SHALL have port mem_ready  input  1  access completes on the edge where mem_req=1 and mem_ready=1; may be combinational from mem_req.
REQ-012 SHALL have port out  output  DATA_W  value of the most recent register write.
REQ-013 SHALL have port halted  output  1  core is in HALT.

Function
REQ-014 Instruction is 32 bits: [31:26] opcode, [25:21] rd, [20:16] rs, [15:11] rt, [15:0] imm; register index = low log2(REG_COUNT) bits of each field.
REQ-015 Opcodes SHALL be: 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs-rt; 3 AND; 4 OR; 5 ADDI rd=rs+sext(imm); 6 LD rd=M[rs+sext(imm)]; 7 ST M[rs+sext(imm)]=rd; 8 BEQ if rd==rs then PC=PC+1+sext(imm); 9 JMP PC=imm; 63 HALT; all other opcodes execute as NOP.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_W; instruction memory is DATA_W wide, with DATA_W<32 taking the low DATA_W bits and upper instruction bits reading as 0; addresses use the low ADDR_W bits of the result; PC wraps at 2^ADDR_W.
REQ-017 Register 0 SHALL read as 0; writes to it are discarded and do not update out.
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on handshake, latch IR, PC<=PC+1, go to DECODE; otherwise hold all state.
REQ-020 DECODE: read rs, rd/rt operands into latches; go to EXEC; HALT opcode goes to HALT.
REQ-021 EXEC: ALU or address compute; R-type/ADDI go to WB; LD/ST go to MEM; BEQ/JMP/NOP update PC as needed and go to FETCH.
REQ-022 MEM: mem_req=1, mem_addr=computed address, mem_we=1 for ST; hold until mem_ready; LD goes to WB with data latched, ST goes to FETCH.
REQ-023 WB: write rd, update out, go to FETCH.
REQ-024 With zero-wait memory, cycles per instruction SHALL be: R-type/ADDI 4, LD 5, ST 4, BEQ/JMP/NOP 3; each cycle mem_ready is low adds one cycle.
REQ-025 mem_req SHALL be 0 outside FETCH and MEM; mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-026 HALT SHALL be terminal: halted=1, no requests, and state is frozen until reset.

Reset
REQ-027 reset low SHALL immediately set state=FETCH, PC=0, IR=0, all registers=0, out=0, halted=0, mem_req=0 (reset asserted mid-access abandons the access).
REQ-028 The first fetch SHALL occur in the first cycle after reset deasserts, at address 0.

Structure
REQ-029 Opcode values, field bit positions and the FSM state encoding SHALL live in a shared package cpu_pkg.
REQ-030 The register file SHALL be a sub-module regfile (parameters DATA_W, REG_COUNT; two async read ports, one sync write port, async active-low reset); the FSM, ALU and PC logic stay in multicycle_cpu.

Verification
REQ-031 ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT with zero-wait memory -> out=12, halted=1 at cycle 16, no requests afterwards.
REQ-032 ST r3 to address 0x40, then LD r4 from 0x40 -> write to 0x40 with data 12, r4=12, LD takes 5 cycles.
REQ-033 mem_ready held low for 3 cycles during a fetch -> mem_addr stable for 4 cycles, CPI increases by 3, no duplicate PC increment.
REQ-034 BEQ r1,r1,+2 skips two instructions; BEQ on unequal operands falls through; JMP 0x0010 -> next fetch address is 0x10.
REQ-035 ADDI r0,r0,9 -> r0 still reads 0 and out unchanged; SUB 0-1 -> all ones.
REQ-036 reset pulsed low during MEM of a ST -> mem_req=0 immediately, no write is completed, and the first fetch after release is at PC=0.
